// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared widths, buffer depth and occupancy helpers for the
//               synchronous FIFO reader.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

  localparam int c_DEFAULT_DATA_WIDTH  = 8;
  localparam int c_DEFAULT_COUNT_WIDTH = 16;
  localparam int c_BUFFER_DEPTH        = 2;

  // Occupancy of the output buffer: 0, 1 or 2 entries.
  typedef logic [1:0] occupancy_t;

  // True when another word can be requested without overrunning the buffer,
  // counting words already stored, words in flight and a pending request.
  function automatic logic has_room(input occupancy_t occupancy,
                                    input logic       in_flight,
                                    input logic       pending);
    return (int'(occupancy) + int'(in_flight) + int'(pending)) < c_BUFFER_DEPTH;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : stream_skid_buffer
// Description : Two-entry in-order output buffer. The head entry drives the
//               stream data; push and pop in the same cycle keep occupancy.
// Revision    : 1.0 - initial release
// ============================================================================
module stream_skid_buffer
  import sync_fifo_pkg::*;
#(
  parameter int p_DATA_WIDTH = c_DEFAULT_DATA_WIDTH
) (
  input  logic                    i_CLK,
  input  logic                    i_RESET_N,
  input  logic                    i_PUSH,
  input  logic [p_DATA_WIDTH-1:0] i_DATA,
  input  logic                    i_POP,
  output logic [p_DATA_WIDTH-1:0] o_DATA,
  output occupancy_t              o_OCCUPANCY
);

  logic [p_DATA_WIDTH-1:0] r_head;
  logic [p_DATA_WIDTH-1:0] r_tail;
  occupancy_t              r_occupancy;

  // Shift-style storage: the head is always the oldest word, the tail the next.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_occupancy <= '0;
    end else begin
      case ({i_PUSH, i_POP})
        2'b10: begin
          if (r_occupancy == 2'd0) begin
            r_head <= i_DATA;
          end else begin
            r_tail <= i_DATA;
          end
          r_occupancy <= r_occupancy + 2'd1;
        end
        2'b01: begin
          r_head      <= r_tail;
          r_occupancy <= r_occupancy - 2'd1;
        end
        2'b11: begin
          // Head leaves; the incoming word lands behind whatever remains.
          if (r_occupancy == 2'd1) begin
            r_head <= i_DATA;
          end else begin
            r_head <= r_tail;
            r_tail <= i_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_DATA      = r_head;
  assign o_OCCUPANCY = r_occupancy;

  a_no_overflow: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
    !(i_PUSH && !i_POP && (r_occupancy == 2'd2)));

  a_no_underflow: assert property (@(posedge i_CLK) disable iff (!i_RESET_N)
    !(i_POP && (r_occupancy == 2'd0)));

endmodule
`default_nettype wire

// File: rtl/sync_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_reader
// Description : Drains a registered-output FIFO into a valid/ready stream.
//               Requests are spaced at least two cycles apart so the lagging
//               empty flag is never trusted twice, and a two-entry buffer
//               absorbs downstream back-pressure.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_reader
  import sync_fifo_pkg::*;
#(
  parameter int p_DATA_WIDTH  = c_DEFAULT_DATA_WIDTH,
  parameter int p_COUNT_WIDTH = c_DEFAULT_COUNT_WIDTH
) (
  input  logic                     i_CLK,
  input  logic                     i_RESET_N,
  input  logic                     i_ENABLE,
  input  logic                     i_FIFO_EMPTY,
  input  logic [p_DATA_WIDTH-1:0]  i_FIFO_DATA,
  output logic                     o_READ_REQUEST,
  output logic                     o_VALID,
  input  logic                     i_READY,
  output logic [p_DATA_WIDTH-1:0]  o_DATA,
  output logic [p_COUNT_WIDTH-1:0] o_COUNT,
  output logic                     o_BUSY
);

  logic                     r_started;
  logic                     r_read_request;
  logic                     r_in_flight;
  logic [p_COUNT_WIDTH-1:0] r_count;
  occupancy_t               w_occupancy;
  logic                     w_transfer;

  assign o_VALID    = (w_occupancy != 2'd0);
  assign w_transfer = o_VALID & i_READY;

  // Issue FIFO reads: one-cycle startup holdoff, never back to back, and only
  // when the buffer can take the word once it returns.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_started      <= 1'b0;
      r_read_request <= 1'b0;
      r_in_flight    <= 1'b0;
    end else begin
      r_started      <= 1'b1;
      r_in_flight    <= r_read_request;
      r_read_request <= r_started & i_ENABLE & ~i_FIFO_EMPTY & ~r_read_request
                        & has_room(w_occupancy, r_in_flight, r_read_request);
    end
  end

  // Count completed stream transfers; wraps naturally at all-ones.
  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      r_count <= '0;
    end else if (w_transfer) begin
      r_count <= r_count + p_COUNT_WIDTH'(1);
    end
  end

  // The FIFO read data is valid during the in-flight cycle and is captured
  // at the edge that closes it.
  stream_skid_buffer #(
    .p_DATA_WIDTH (p_DATA_WIDTH)
  ) u_skid_buffer (
    .i_CLK       (i_CLK),
    .i_RESET_N   (i_RESET_N),
    .i_PUSH      (r_in_flight),
    .i_DATA      (i_FIFO_DATA),
    .i_POP       (w_transfer),
    .o_DATA      (o_DATA),
    .o_OCCUPANCY (w_occupancy)
  );

  assign o_READ_REQUEST = r_read_request;
  assign o_COUNT        = r_count;
  assign o_BUSY         = (w_occupancy != 2'd0) | r_in_flight | r_read_request;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo_reader
// Description : Self-checking bench for sync_fifo_reader with a registered
//               FIFO model and an in-order word scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_reader;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          i_CLK = 1'b0;
  logic          i_RESET_N = 1'b1;
  logic          i_ENABLE = 1'b0;
  logic          i_READY = 1'b0;
  logic          i_FIFO_EMPTY = 1'b1;
  logic [DW-1:0] i_FIFO_DATA = '0;
  logic          o_READ_REQUEST;
  logic          o_VALID;
  logic          o_BUSY;
  logic [DW-1:0] o_DATA;
  logic [CW-1:0] o_COUNT;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            req_cycles[$];
  int            req_seen    = 0;
  int            b2b         = 0;
  int            underflow   = 0;
  int            cyc         = 0;
  int            first_valid = -1;
  int            rel_cyc     = 0;
  bit            prev_req    = 1'b0;

  sync_fifo_reader #(
    .p_DATA_WIDTH  (DW),
    .p_COUNT_WIDTH (CW)
  ) dut (
    .i_CLK          (i_CLK),
    .i_RESET_N      (i_RESET_N),
    .i_ENABLE       (i_ENABLE),
    .i_FIFO_EMPTY   (i_FIFO_EMPTY),
    .i_FIFO_DATA    (i_FIFO_DATA),
    .o_READ_REQUEST (o_READ_REQUEST),
    .o_VALID        (o_VALID),
    .i_READY        (i_READY),
    .o_DATA         (o_DATA),
    .o_COUNT        (o_COUNT),
    .o_BUSY         (o_BUSY)
  );

  always #5 i_CLK = ~i_CLK;

  // FIFO model: registered read data; empty flag reflects a read one edge later.
  always @(posedge i_CLK) begin
    cyc <= cyc + 1;
    if (o_READ_REQUEST) begin
      if (fifo_q.size() > 0) i_FIFO_DATA <= fifo_q.pop_front();
      else underflow <= underflow + 1;
    end
    i_FIFO_EMPTY <= (fifo_q.size() == 0);
  end

  // Monitor: records words that transfer at the coming edge and request timing.
  always @(negedge i_CLK) begin
    if (i_RESET_N) begin
      if (o_VALID && i_READY) got_q.push_back(o_DATA);
      if (o_VALID && first_valid < 0) first_valid = cyc;
      if (o_READ_REQUEST) begin
        req_seen++;
        req_cycles.push_back(cyc);
        if (prev_req) b2b++;
      end
      prev_req = o_READ_REQUEST;
    end else begin
      prev_req = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge i_CLK);
    #1;
  endtask

  task automatic start_test();
    i_RESET_N = 1'b0;
    i_ENABLE  = 1'b0;
    i_READY   = 1'b0;
    tick(2);
    fifo_q.delete();
    exp_q.delete();
    got_q.delete();
    req_cycles.delete();
    req_seen    = 0;
    first_valid = -1;
  endtask

  task automatic load(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic release_reset();
    tick(1);
    i_RESET_N = 1'b1;
    rel_cyc   = cyc;
  endtask

  task automatic wait_got(input int n, input int budget, output bit ok);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    ok = (got_q.size() >= n);
  endtask

  task automatic wait_req(output bit ok);
    int k = 0;
    while (!o_READ_REQUEST && k < 30) begin
      tick(1);
      k++;
    end
    ok = o_READ_REQUEST;
  endtask

  task automatic test_reset();
    start_test();
    n_cmp++; if (o_READ_REQUEST !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", o_READ_REQUEST); end
    n_cmp++; if (o_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_VALID); end
    n_cmp++; if (o_DATA !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", o_DATA); end
    n_cmp++; if (o_COUNT !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", o_COUNT); end
    n_cmp++; if (o_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", o_BUSY); end
  endtask

  task automatic test_in_order();
    bit ok;
    logic [DW-1:0] w_exp, w_got;
    start_test();
    load(8'h11); load(8'h22); load(8'h33);
    i_ENABLE = 1'b1;
    i_READY  = 1'b1;
    release_reset();
    wait_got(3, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL in_order_timeout: got %0d words expected 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      w_exp = exp_q.pop_front();
      w_got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (w_got !== w_exp) begin n_fail++; $display("FAIL in_order_word%0d: got %h expected %h", i, w_got, w_exp); end
    end
    tick(4);
    n_cmp++; if (o_COUNT !== 4'd3) begin n_fail++; $display("FAIL in_order_count: got %0d expected 3", o_COUNT); end
    n_cmp++; if (o_BUSY !== 1'b0) begin n_fail++; $display("FAIL in_order_idle_busy: got %b expected 0", o_BUSY); end
    n_cmp++; if (req_seen !== 3) begin n_fail++; $display("FAIL in_order_requests: got %0d expected 3", req_seen); end
    if (req_cycles.size() >= 3) begin
      n_cmp++; if (req_cycles[1] - req_cycles[0] !== 2) begin n_fail++; $display("FAIL in_order_spacing1: got %0d expected 2", req_cycles[1] - req_cycles[0]); end
      n_cmp++; if (req_cycles[2] - req_cycles[1] !== 2) begin n_fail++; $display("FAIL in_order_spacing2: got %0d expected 2", req_cycles[2] - req_cycles[1]); end
      n_cmp++; if (first_valid - req_cycles[0] !== 2) begin n_fail++; $display("FAIL in_order_latency: got %0d expected 2", first_valid - req_cycles[0]); end
      n_cmp++; if (req_cycles[0] - rel_cyc < 2) begin n_fail++; $display("FAIL startup_holdoff: got %0d expected >=2", req_cycles[0] - rel_cyc); end
    end else begin
      n_cmp++; n_fail++; $display("FAIL in_order_req_log: got %0d requests expected 3", req_cycles.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [DW-1:0] w_exp, w_got;
    start_test();
    load(8'hA1); load(8'hA2); load(8'hA3); load(8'hA4);
    i_ENABLE = 1'b1;
    release_reset();
    tick(20);
    n_cmp++; if (req_seen !== 2) begin n_fail++; $display("FAIL bp_requests: got %0d expected 2", req_seen); end
    n_cmp++; if (o_READ_REQUEST !== 1'b0) begin n_fail++; $display("FAIL bp_req_idle: got %b expected 0", o_READ_REQUEST); end
    n_cmp++; if (o_VALID !== 1'b1) begin n_fail++; $display("FAIL bp_valid: got %b expected 1", o_VALID); end
    n_cmp++; if (o_DATA !== 8'hA1) begin n_fail++; $display("FAIL bp_data: got %h expected a1", o_DATA); end
    tick(5);
    n_cmp++; if (o_VALID !== 1'b1 || o_DATA !== 8'hA1) begin n_fail++; $display("FAIL bp_hold: got valid %b data %h expected valid 1 data a1", o_VALID, o_DATA); end
    i_READY = 1'b1;
    wait_got(4, 40, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL bp_timeout: got %0d words expected 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      w_exp = exp_q.pop_front();
      w_got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      n_cmp++; if (w_got !== w_exp) begin n_fail++; $display("FAIL bp_word%0d: got %h expected %h", i, w_got, w_exp); end
    end
    tick(2);
    n_cmp++; if (o_COUNT !== 4'd4) begin n_fail++; $display("FAIL bp_count: got %0d expected 4", o_COUNT); end
  endtask

  task automatic test_single_word();
    start_test();
    load(8'hA5);
    i_ENABLE = 1'b1;
    i_READY  = 1'b1;
    release_reset();
    tick(15);
    n_cmp++; if (req_seen !== 1) begin n_fail++; $display("FAIL single_requests: got %0d expected 1", req_seen); end
    n_cmp++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL single_words: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", got_q[0]); end
    end
  endtask

  task automatic test_wrap();
    bit ok;
    logic [DW-1:0] w_exp, w_got;
    int bad = 0;
    start_test();
    for (int i = 0; i < 17; i++) load(8'(8'h40 + i));
    i_ENABLE = 1'b1;
    i_READY  = 1'b1;
    release_reset();
    wait_got(17, 150, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL wrap_timeout: got %0d words expected 17", got_q.size()); end
    for (int i = 0; i < 17; i++) begin
      w_exp = exp_q.pop_front();
      w_got = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
      if (w_got !== w_exp) begin
        if (bad == 0) $display("FAIL wrap_word%0d: got %h expected %h", i, w_got, w_exp);
        bad++;
      end
    end
    n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL wrap_order: got %0d bad words expected 0", bad); end
    tick(3);
    n_cmp++; if (o_COUNT !== 4'd1) begin n_fail++; $display("FAIL wrap_count: got %0d expected 1", o_COUNT); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start_test();
    fifo_q.push_back(8'h5A);   // read by the interrupted request and lost
    load(8'h6B);
    i_ENABLE = 1'b1;
    i_READY  = 1'b1;
    release_reset();
    wait_req(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_req_timeout: got %b expected 1", o_READ_REQUEST); end
    tick(1);
    i_RESET_N = 1'b0;
    #1;
    n_cmp++; if ({o_READ_REQUEST, o_VALID, o_BUSY} !== 3'b000 || o_DATA !== 8'h00 || o_COUNT !== 4'd0) begin
      n_fail++; $display("FAIL rmid_outputs: got req %b valid %b busy %b data %h count %0d expected all 0", o_READ_REQUEST, o_VALID, o_BUSY, o_DATA, o_COUNT);
    end
    tick(2);
    i_RESET_N = 1'b1;
    wait_got(1, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL rmid_timeout: got %0d words expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== exp_q[0]) begin n_fail++; $display("FAIL rmid_data: got %h expected %h", got_q[0], exp_q[0]); end
    end
    tick(2);
    n_cmp++; if (o_COUNT !== 4'd1) begin n_fail++; $display("FAIL rmid_count: got %0d expected 1", o_COUNT); end
  endtask

  task automatic test_enable_drop();
    bit ok;
    start_test();
    load(8'h31); load(8'h42);
    i_ENABLE = 1'b1;
    i_READY  = 1'b1;
    release_reset();
    wait_req(ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL en_req_timeout: got %b expected 1", o_READ_REQUEST); end
    tick(1);
    i_ENABLE = 1'b0;
    tick(12);
    n_cmp++; if (req_seen !== 1) begin n_fail++; $display("FAIL en_requests: got %0d expected 1", req_seen); end
    n_cmp++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL en_words: got %0d expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q.pop_front() !== exp_q[0]) begin n_fail++; $display("FAIL en_data: got other expected %h", exp_q[0]); end
    end
    i_ENABLE = 1'b1;
    wait_got(1, 30, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL en_resume_timeout: got %0d words expected 1", got_q.size()); end
    if (got_q.size() > 0) begin
      n_cmp++; if (got_q[0] !== exp_q[1]) begin n_fail++; $display("FAIL en_resume_data: got %h expected %h", got_q[0], exp_q[1]); end
    end
    n_cmp++; if (req_seen !== 2) begin n_fail++; $display("FAIL en_resume_requests: got %0d expected 2", req_seen); end
  endtask

  task automatic test_invariants();
    n_cmp++; if (b2b !== 0) begin n_fail++; $display("FAIL back_to_back_requests: got %0d expected 0", b2b); end
    n_cmp++; if (underflow !== 0) begin n_fail++; $display("FAIL fifo_underflow: got %0d expected 0", underflow); end
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_backpressure();
    test_single_word();
    test_wrap();
    test_reset_mid();
    test_enable_drop();
    test_invariants();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
